mips_run_controller: RTL
========================

# mips_run_controller

Execution sequencer for the single-cycle MIPS core: owns a clock-enable (`Core_En`) that gates PC update, register-file write and data-memory write, and starts, stops, single-steps and halts the core. Halts on an external stop, a PC breakpoint, a halt instruction word or a cycle watchdog, and records the cause. It sits beside the `MIPS` top and observes the core's `PC` and `Instr`. While `Core_En` is low, the core holds all architectural state.

## Interface
- `WIDTH`, 32, PC/instruction/breakpoint width
- `CNT_WIDTH`, 32, cycle counter width
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that halts the core
- `WDOG_LIMIT`, 0, executed-cycle limit in RUN; 0 disables the watchdog

- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `Start`  in  1  level-sampled request to run
- `Stop`  in  1  request to halt
- `Step`  in  1  request to execute exactly one instruction
- `BP_En`  in  1  breakpoint enable
- `BP_Addr`  in  WIDTH  breakpoint PC
- `PC`  in  WIDTH  current core PC
- `Instr`  in  WIDTH  instruction at `PC`
- `Core_En`  out  1  core commit enable (combinational)
- `State`  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALTED (registered)
- `Halt_Cause`  out  3  0 none, 1 stop, 2 breakpoint, 3 halt instruction, 4 step done, 5 watchdog (registered)
- `Cycle_Count`  out  CNT_WIDTH  number of cycles with `Core_En`=1, saturating

## Operation
- States:
  - **IDLE:** after reset.
  - **RUN:** free-running.
  - **STEP:** one instruction.
  - **HALTED:** stopped with cause.
- **IDLE transitions:**
  - `Start` -> RUN; clears `Cycle_Count`.
  - else `Step` -> STEP; clears `Cycle_Count`.
  - `Start` wins over `Step`.
- **HALTED transitions:**
  - `Start` -> RUN; `Cycle_Count` is kept.
  - else `Step` -> STEP.
  - `Start` is ignored when `Halt_Cause`=3, because the core would re-execute the halt word; `Step` is also ignored in that case.
  - Leaving HALTED clears `Halt_Cause` to 0.
- **Halt conditions in RUN, evaluated combinationally on the current `PC`/`Instr`, priority high->low:**
  - `Stop` -> cause 1
  - `Instr`==`HALT_WORD` -> cause 3
  - `WDOG_LIMIT`!=0 and `Cycle_Count`==`WDOG_LIMIT` -> cause 5
  - `BP_En` and `PC`==`BP_Addr` -> cause 2
- **When a halt condition is true:**
  - `Core_En`=0 that cycle, so the instruction is not committed.
  - Next state is HALTED and the cause is latched.
- **Breakpoint skip:**
  - The first RUN cycle after entering from HALTED ignores the breakpoint. This allows resuming from the breakpoint PC.
  - It is implemented as a one-cycle skip flag set on the HALTED->RUN transition.
- **STEP:**
  - The halt-instruction check applies and halts with cause 3.
  - Breakpoint, `Stop` and watchdog are ignored.
  - Otherwise `Core_En`=1 for exactly one cycle, then HALTED with cause 4.
- **RUN/STEP input handling:** `Start`/`Step` are ignored. `Stop` is ignored outside RUN.
- **`Cycle_Count`:** increments on every cycle with `Core_En`=1 and saturates at all-ones.
- **`Core_En`** = (`State`==RUN and no halt condition) or (`State`==STEP and `Instr`!=`HALT_WORD`), forced to 0 while `RST`=1.

## Timing
- **Reset (after the edge with `RST`=1):** `State`=IDLE, `Halt_Cause`=0, `Cycle_Count`=0, skip flag=0.
- **During reset:** `Core_En`=0 combinationally throughout any cycle with `RST`=1.
- **Reset mid-RUN or mid-STEP:** aborts the operation. No commit occurs in the reset cycle.
- **Start latency:** `Start` sampled at edge N gives `State`=RUN after N, and the first `Core_En`=1 in cycle N+1. There are no commits in the request cycle.
- **Halt latency:** the halt decision is in the same cycle: `Core_En` drops in the cycle the condition appears. `State`=HALTED and `Halt_Cause` are visible after the next edge.
- **Step:** exactly one `Core_En` pulse, in the cycle after `Step` is sampled.
- **Watchdog:** with limit L, exactly L instructions commit before the halt.
- **Counter saturation:** `Cycle_Count` stays at its maximum value. The watchdog compare still works when L equals the maximum.

## Test plan
- **Run to halt word:** program of 5 instructions + `HALT_WORD` at PC 0x14, `Start` for 1 cycle -> 5 `Core_En` cycles, `State`=3, `Halt_Cause`=3, `Cycle_Count`=5. A second `Start` is ignored.
- **Breakpoint and resume:** `BP_En`=1, `BP_Addr`=0x08, Start -> halt with PC=0x08, cause 2, count 2. Start again -> the instruction at 0x08 commits, run continues to the halt word.
- **Single step:** from IDLE, Step ×3 with gaps -> 3 single `Core_En` pulses, PC 0x0->0x4->0x8->0xC, cause 4 after each, count 3. A breakpoint at 0x4 does not stop stepping.
- **Stop vs breakpoint:** `Stop` asserted in the same cycle PC==`BP_Addr` -> cause 1 and no commit that cycle.
- **Watchdog:** `WDOG_LIMIT`=10 with an infinite loop -> exactly 10 commits, cause 5.
- **Reset mid-run:** `RST` pulsed during RUN -> `Core_En`=0 in that cycle, then `State`=0, count 0, cause 0. `Start`+`Step` together -> RUN.

Source files
------------

// File: rtl/mips_run_controller_if.sv
// mips_run_controller_if
//   Groups the run-control request inputs, the observed core PC/instruction
//   and the controller status outputs.
//   master : debugger/core side (drives requests, PC, Instr)
//   slave  : mips_run_controller (drives Core_En, State, Halt_Cause,
//            Cycle_Count)
interface mips_run_controller_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 Start;
  logic                 Stop;
  logic                 Step;
  logic                 BP_En;
  logic [WIDTH-1:0]     BP_Addr;
  logic [WIDTH-1:0]     PC;
  logic [WIDTH-1:0]     Instr;
  logic                 Core_En;
  logic [1:0]           State;
  logic [2:0]           Halt_Cause;
  logic [CNT_WIDTH-1:0] Cycle_Count;

  modport master (
    output Start, Stop, Step, BP_En, BP_Addr, PC, Instr,
    input  Core_En, State, Halt_Cause, Cycle_Count
  );

  modport slave (
    input  Start, Stop, Step, BP_En, BP_Addr, PC, Instr,
    output Core_En, State, Halt_Cause, Cycle_Count
  );
endinterface

// File: rtl/mips_run_controller.sv
// mips_run_controller
//   Execution sequencer for the single-cycle MIPS core. Owns Core_En, the
//   commit enable gating PC update, register-file write and data-memory
//   write. Starts, stops, single-steps and halts the core; halts on Stop,
//   PC breakpoint, halt instruction word or cycle watchdog and records why.
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   ctl  - slave side of mips_run_controller_if:
//          in : Start, Stop, Step, BP_En, BP_Addr, PC, Instr
//          out: Core_En (comb), State, Halt_Cause (registered),
//               Cycle_Count (saturating count of Core_En cycles)
module mips_run_controller #(
  parameter int unsigned          WIDTH      = 32,
  parameter int unsigned          CNT_WIDTH  = 32,
  parameter logic [WIDTH-1:0]     HALT_WORD  = '1,
  parameter logic [CNT_WIDTH-1:0] WDOG_LIMIT = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  mips_run_controller_if.slave  ctl
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_STOP = 3'd1,
    C_BP   = 3'd2,
    C_HALT = 3'd3,
    C_STEP = 3'd4,
    C_WDOG = 3'd5
  } cause_e;

  state_e               state_q, state_d;
  cause_e               cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 skip_q, skip_d;

  cause_e               run_cause;
  logic                 is_halt_word;
  logic                 wdog_hit;
  logic                 cnt_clr;
  logic                 core_en;

  assign is_halt_word = (ctl.Instr == HALT_WORD);
  assign wdog_hit     = (WDOG_LIMIT != '0) && (cnt_q == WDOG_LIMIT);

  // Halt condition while running, highest priority first. The breakpoint
  // is masked on the first RUN cycle after a resume so the core can leave
  // the breakpoint PC.
  always_comb begin
    run_cause = C_NONE;
    if (ctl.Stop)
      run_cause = C_STOP;
    else if (is_halt_word)
      run_cause = C_HALT;
    else if (wdog_hit)
      run_cause = C_WDOG;
    else if (ctl.BP_En && (ctl.PC == ctl.BP_Addr) && !skip_q)
      run_cause = C_BP;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    skip_d  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl.Start) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
        end else if (ctl.Step) begin
          state_d = S_STEP;
          cnt_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (run_cause != C_NONE) begin
          state_d = S_HALTED;
          cause_d = run_cause;
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
        cause_d = is_halt_word ? C_HALT : C_STEP;
      end
      S_HALTED: begin
        // Resuming onto a halt word would just re-halt, so stay put.
        if (cause_q != C_HALT) begin
          if (ctl.Start) begin
            state_d = S_RUN;
            cause_d = C_NONE;
            skip_d  = 1'b1;
          end else if (ctl.Step) begin
            state_d = S_STEP;
            cause_d = C_NONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cnt_clr)
      cnt_d = '0;
    else if (core_en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  // Output logic
  always_comb begin
    core_en = 1'b0;
    if (!RST) begin
      if (state_q == S_RUN)
        core_en = (run_cause == C_NONE);
      else if (state_q == S_STEP)
        core_en = !is_halt_word;
    end
  end

  assign ctl.Core_En     = core_en;
  assign ctl.State       = state_q;
  assign ctl.Halt_Cause  = cause_q;
  assign ctl.Cycle_Count = cnt_q;

endmodule
